// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words and writes them to consecutive addresses. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   load_len,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          full,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [23:0]   asm_q, asm_d;
   logic          s_ready_q, s_ready_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          full_q, full_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   csum_q, csum_d;
   logic          err_q, err_d;
`endif

   logic          accept;
   logic          last_byte;
   logic [31:0]   rx_word;

   assign accept    = s_ready_q && s_valid;
   assign last_byte = accept && (byte_idx_q == 2'd3);
   assign rx_word   = {s_data, asm_q};

   always_comb begin
      // NOTE: every _d gets a default here so no latch is inferred on paths that skip it.
      state_d     = state_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      byte_idx_d  = byte_idx_q;
      asm_d       = asm_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      full_d      = full_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
      err_d       = err_q;
`endif

      // Byte lanes fill low-to-high; the fourth byte is consumed directly from s_data.
      if (accept) begin
         byte_idx_d = byte_idx_q + 2'd1;
         case (byte_idx_q)
            2'd0:    asm_d[7:0]   = s_data;
            2'd1:    asm_d[15:8]  = s_data;
            2'd2:    asm_d[23:16] = s_data;
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (start && (load_len != '0)) begin
               state_d    = S_LOAD;
               len_d      = (load_len > DEPTH_W) ? DEPTH_W : load_len;
               word_cnt_d = '0;
               byte_idx_d = '0;
               full_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
               err_d      = 1'b0;
`endif
            end
         end

         S_LOAD: begin
            if (last_byte) begin
               mem_addr_d  = word_cnt_q;
               mem_wdata_d = rx_word;
               state_d     = S_WRITE;
            end
         end

         S_WRITE: begin
            if (word_cnt_q == LAST_ADDR) full_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ mem_wdata_q;
`endif
            if ({1'b0, word_cnt_q} == (len_q - 1'b1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = S_LOAD;
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (last_byte) begin
               if (rx_word != csum_q) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the state register.
      s_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
      mem_we_d  = (state_d == S_WRITE);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         word_cnt_q  <= '0;
         byte_idx_q  <= '0;
         asm_q       <= '0;
         s_ready_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q     <= state_d;
         len_q       <= len_d;
         word_cnt_q  <= word_cnt_d;
         byte_idx_q  <= byte_idx_d;
         asm_q       <= asm_d;
         s_ready_q   <= s_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         full_q      <= full_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
         err_q       <= err_d;
`endif
      end
   end

   assign s_ready   = s_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign cpu_hold  = busy_q;
   assign done      = done_q;
   assign full      = full_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte stream in, logged memory writes checked
// against hand-computed words. Checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW:0]   load_len;
   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          full;
   logic          err;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .load_len  (load_len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .full      (full),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cyc = -1;
   int          log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];
   logic [31:0] tb_xor;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] la(input int i);
      return (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ld(input int i);
      return (i < log_data.size()) ? log_data[i] : 32'hFFFF_FFFF;
   endfunction

   // Write logger plus the s_ready invariant: low in WRITE/DONE, high elsewhere while busy.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst_n) begin
         if (mem_we) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
         end
         if (done) done_cyc = cyc;
         if (mem_we || done) check("s_ready_low", 32'(s_ready), 32'd0);
         else if (busy)      check("s_ready_high", 32'(s_ready), 32'd1);
      end
   end

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      if (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("s_ready_wait", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
      tb_xor = tb_xor ^ w;
   endtask

   task automatic start_load(input logic [AW:0] len);
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
      done_cyc = -1;
      tb_xor   = '0;
      start    = 1'b1;
      load_len = len;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", 32'(done), 32'd1);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("hold_after_done", 32'(cpu_hold), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [31:0] c;
      c = tb_xor;
      for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8], 1'b0);
`endif
      wait_done();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"},   32'(s_ready),  32'd0);
      check({tag, "_mem_we"},    32'(mem_we),   32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,     32'd0);
      check({tag, "_cpu_hold"},  32'(cpu_hold), 32'd0);
      check({tag, "_busy"},      32'(busy),     32'd0);
      check({tag, "_done"},      32'(done),     32'd0);
      check({tag, "_full"},      32'(full),     32'd0);
      check({tag, "_err"},       32'(err),      32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      load_len = '0;
      s_valid  = 1'b0;
      s_data   = '0;
      tb_xor   = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic two-word load with s_valid held high
      start_load(9'd2);
      check("start_busy", 32'(busy), 32'd1);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_ready", 32'(s_ready), 32'd1);
      send_word(32'h0000_0013, 1'b0);
      send_word(32'h0010_0093, 1'b0);
      finish_load();
      check("basic_nwr", 32'(log_addr.size()), 32'd2);
      check("basic_a0", la(0), 32'd0);
      check("basic_d0", ld(0), 32'h0000_0013);
      check("basic_a1", la(1), 32'd1);
      check("basic_d1", ld(1), 32'h0010_0093);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("basic_done_lat", 32'(done_cyc), 32'(log_cyc[1] + 1));
`endif

      // Gapped s_valid, one word
      start_load(9'd1);
      send_word(32'hDEAD_BEEF, 1'b1);
      finish_load();
      check("gap_nwr", 32'(log_addr.size()), 32'd1);
      check("gap_a0", la(0), 32'd0);
      check("gap_d0", ld(0), 32'hDEAD_BEEF);

      // load_len=0 is ignored
      start    = 1'b1;
      load_len = '0;
      @(negedge clk);
      start    = 1'b0;
      check("zero_len_busy", 32'(busy), 32'd0);
      check("zero_len_ready", 32'(s_ready), 32'd0);

      // Clamp to DEPTH and full flag
      start_load(9'd300);
      for (int i = 0; i < DEPTH; i++) send_word({8'hA5, 8'hC3, 8'h5A, i[7:0]}, 1'b0);
      finish_load();
      check("clamp_full", 32'(full), 32'd1);
      check("clamp_nwr", 32'(log_addr.size()), 32'd256);
      for (int i = 0; i < DEPTH; i++) begin
         check("clamp_addr", la(i), 32'(i));
         check("clamp_data", ld(i), {8'hA5, 8'hC3, 8'h5A, i[7:0]});
      end
      check("clamp_err", 32'(err), 32'd0);

      // Second start mid-load must not restart the count
      start_load(9'd2);
      check("restart_full_clr", 32'(full), 32'd0);
      send_word(32'hCAFE_F00D, 1'b0);
      start    = 1'b1;
      load_len = 9'd5;
      @(negedge clk);
      start    = 1'b0;
      send_word(32'h0BAD_C0DE, 1'b0);
      finish_load();
      check("midstart_nwr", 32'(log_addr.size()), 32'd2);
      check("midstart_a1", la(1), 32'd1);
      check("midstart_d1", ld(1), 32'h0BAD_C0DE);

      // Asynchronous reset after two bytes of the second word
      start_load(9'd2);
      send_word(32'h0102_0304, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_load(9'd1);
      send_word(32'h1234_5678, 1'b0);
      finish_load();
      check("postrst_nwr", 32'(log_addr.size()), 32'd1);
      check("postrst_a0", la(0), 32'd0);
      check("postrst_d0", ld(0), 32'h1234_5678);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Good checksum
      start_load(9'd2);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'h33, 1'b0);
      wait_done();
      check("csum_good_err", 32'(err), 32'd0);

      // Bad checksum 0x33333334: err sticks until the next start
      start_load(9'd2);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b0);
      send_byte(8'h34, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'h33, 1'b0);
      wait_done();
      check("csum_bad_err", 32'(err), 32'd1);
      repeat (5) @(negedge clk);
      check("csum_bad_sticky", 32'(err), 32'd1);
      start_load(9'd1);
      check("csum_err_clr", 32'(err), 32'd0);
      send_word(32'h0000_0001, 1'b0);
      finish_load();
      check("csum_final_err", 32'(err), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time programmer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles bytes into little-endian 32-bit instructions. Writes each instruction into consecutive word addresses through the memory's write-enable port, and holds the CPU fetch path off while loading. Sits between the top-level debug/UART byte source and the instruction memory write port (enable/address/data).

## Interface
- DEPTH, 256: instruction memory size in 32-bit words.
- AW, 8: word address width, $clog2(DEPTH).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- load_len  in  AW+1  number of instruction words to load; sampled with start.
- s_valid  in  1  byte source has data.
- s_data  in  8  byte payload.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  AW  word address of the write.
- mem_wdata  out  32  instruction to write.
- cpu_hold  out  1  stalls CPU fetch while high.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on load completion.
- full  out  1  sticky; last word address DEPTH-1 was written.
- err  out  1  checksum mismatch, sticky; tied 0 without the macro.

## Operation
- States: IDLE, LOAD, WRITE, CHECK (macro only), DONE. All outputs are registered.
- IDLE: s_ready=0, mem_we=0, cpu_hold=0. On start with load_len≠0, go to LOAD and set:
  - len=min(load_len, DEPTH), word_cnt=0, byte_idx=0.
  - full=0, err=0.
- start with load_len=0 is ignored. start outside IDLE is ignored.
- LOAD: s_ready=1. Each handshake (s_valid&&s_ready) writes s_data into lane byte_idx; the first byte lands in [7:0]. byte_idx increments mod 4. The 4th byte registers the word and moves to WRITE.
- WRITE: s_ready=0, mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word, for exactly one cycle.
  - If word_cnt==DEPTH-1, set full.
  - If word_cnt==len-1: go to DONE, or to CHECK with the macro.
  - Otherwise: word_cnt++ and return to LOAD.
- DONE: done=1 for one cycle, then IDLE. cpu_hold falls on the same edge that leaves DONE.
- Address never wraps. The load ends at len ≤ DEPTH words.
- Reset mid-load: every output returns to 0 asynchronously and the state returns to IDLE. Words already written stay in memory. A partially assembled word is discarded.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, full=0, err=0.
- The start edge is edge k. busy, cpu_hold and s_ready are high from edge k through the cycle after it.
- Minimum 5 cycles per word: 4 accepts plus 1 write. s_valid gaps stretch LOAD only.
- done is high in the cycle after the final WRITE, or after the final CHECK accept with the macro. busy and cpu_hold are low in the cycle after done.
- s_ready is low during WRITE and DONE. s_valid may stay high; no byte is lost or duplicated.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The loader keeps a running XOR of all written words, cleared at start.
  - After the last WRITE it enters CHECK, which accepts 4 more bytes (little-endian) with s_ready=1 and no memory write.
  - If the received word differs from the running XOR, err=1 (sticky until the next start). Then DONE.
- Not defined: no CHECK state; err is constant 0; DONE follows the last WRITE directly.

## Test plan
- Basic load:
  - Stimulus: start, load_len=2, bytes 13 00 00 00 93 00 10 00 with s_valid held high.
  - Required: mem_we at addr 0 with 0x00000013, then at addr 1 with 0x00100093. done 1 cycle after the 2nd write. cpu_hold low after done.
- Back-pressure/gaps: s_valid toggling every other cycle during a 1-word load of 0xDEADBEEF.
  - Required: single write of 0xDEADBEEF; s_ready low exactly in the WRITE and DONE cycles.
- Full/clamp: start, load_len=300, with DEPTH=256.
  - Required: 256 writes at addr 0..255; full=1 after the addr-255 write; no write to addr 0 afterwards.
- Ignored requests: load_len=0 in IDLE leaves busy=0. A second start mid-load does not reset word_cnt.
- Reset mid-load: drop rst_n after 2 bytes of word 1.
  - Required: all outputs 0 immediately.
  - Follow-up: a new load of 1 word writes addr 0 with correctly aligned bytes.
- Checksum (macro): words 0x11111111 and 0x22222222 followed by checksum 0x33333333 gives err=0. Followed by 0x33333334, err=1 is held until the next start.
